// File: rtl/des_pkg.sv
// DES S-box constants and lookup helper shared by the substitution pipeline.
// Each 64-bit row holds 16 nibbles, column 0 at bits 63:60.
package des_pkg;

  localparam int unsigned SBOX_IN_W  = 6;
  localparam int unsigned SBOX_OUT_W = 4;
  localparam int unsigned N_SBOX     = 8;

  typedef logic [63:0] sbox_row_t;

  localparam sbox_row_t SBOX_LUT [0:7][0:3] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

  // Row is the outer bit pair {b5,b0}, column the middle four bits.
  function automatic logic [SBOX_OUT_W-1:0] sbox_lookup(input logic [2:0]           box,
                                                        input logic [SBOX_IN_W-1:0] in6);
    logic [1:0] row;
    logic [3:0] col;
    logic [5:0] shamt;
    sbox_row_t  word;
    row   = {in6[5], in6[0]};
    col   = in6[4:1];
    shamt = 6'd60 - {col, 2'b00};
    word  = SBOX_LUT[box][row] >> shamt;
    return word[SBOX_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// Single combinational DES S-box; BOX selects S1..S8 (0..7).
module des_sbox_lut
  import des_pkg::*;
#(
  parameter int unsigned BOX = 0
) (
  input  logic [SBOX_IN_W-1:0]  i_data,
  output logic [SBOX_OUT_W-1:0] o_data
);

  always_comb begin
    o_data = sbox_lookup(3'(BOX), i_data);
  end

endmodule

// File: rtl/des_sbox_pipe.sv
// Registered DES substitution stage with valid/ready handshake, 1-cycle latency.
// Define DES_SBOX_CNT_EN to add the saturating xfer_cnt output-handshake counter.
module des_sbox_pipe
  import des_pkg::*;
#(
  parameter int unsigned N_BOX     = 8,
  parameter int unsigned FIRST_BOX = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SBOX_IN_W*N_BOX-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SBOX_OUT_W*N_BOX-1:0] out_data
`ifdef DES_SBOX_CNT_EN
  ,
  output logic [15:0]                 xfer_cnt
`endif
);

  if ((N_BOX < 1) || (FIRST_BOX + N_BOX > N_SBOX)) begin : g_bad_cfg
    $error("des_sbox_pipe: FIRST_BOX+N_BOX must be <= 8 and N_BOX >= 1");
  end

  logic [SBOX_OUT_W*N_BOX-1:0] w_sbox;
  logic                        w_accept;
  logic                        w_pop;
  logic                        w_valid_d;
  logic                        r_valid;
  logic [SBOX_OUT_W*N_BOX-1:0] r_data;

  for (genvar i = 0; i < int'(N_BOX); i++) begin : g_box
    des_sbox_lut #(
      .BOX (FIRST_BOX + i)
    ) u_lut (
      .i_data (in_data[SBOX_IN_W*(N_BOX-i)-1 -: SBOX_IN_W]),
      .o_data (w_sbox[SBOX_OUT_W*(N_BOX-i)-1 -: SBOX_OUT_W])
    );
  end

  assign in_ready  = !r_valid || out_ready;
  assign w_accept  = in_valid && in_ready && !clr;
  assign w_pop     = r_valid && out_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  // clr beats everything; an accept overrides a same-cycle pop (no bubble).
  always_comb begin
    w_valid_d = r_valid;
    if (clr) begin
      w_valid_d = 1'b0;
    end else if (w_accept) begin
      w_valid_d = 1'b1;
    end else if (w_pop) begin
      w_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_valid_d;
      if (w_accept) begin
        r_data <= w_sbox;
      end
    end
  end

`ifdef DES_SBOX_CNT_EN
  logic [15:0] r_xfer_cnt;
  logic [15:0] w_xfer_cnt_d;

  always_comb begin
    w_xfer_cnt_d = r_xfer_cnt;
    if (clr) begin
      w_xfer_cnt_d = '0;
    end else if (w_pop && (r_xfer_cnt != 16'hFFFF)) begin
      w_xfer_cnt_d = r_xfer_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else begin
      r_xfer_cnt <= w_xfer_cnt_d;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_des_sbox_pipe.sv
// Scoreboard bench for des_sbox_pipe (8-box instance) plus a 1-box instance.
`timescale 1ns/1ps
module tb_des_sbox_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [47:0] in_data = '0;
  logic [31:0] out_data;

  logic        in1_valid = 1'b0;
  logic        in1_ready;
  logic        out1_valid;
  logic [5:0]  in1_data = '0;
  logic [3:0]  out1_data;

`ifdef DES_SBOX_CNT_EN
  logic [15:0] xfer_cnt;
  logic [15:0] xfer_cnt1;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_pop    = 0;
  logic [31:0] q[$];

  // Standard DES S-box tables, row-major, decimal.
  byte unsigned sb [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,     0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,     15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,     3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,     13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,     13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,     1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,     13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,     3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,     14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,     11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,     10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,     4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,     13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,     6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,     1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,     2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  function automatic logic [31:0] ref_sub(input logic [47:0] d);
    logic [31:0] r;
    logic [5:0]  b;
    int          idx;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      b   = d[47-6*k -: 6];
      idx = {b[5], b[0]} * 16 + int'(b[4:1]);
      r[31-4*k -: 4] = sb[k][idx][3:0];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  always #5 clk = ~clk;

  des_sbox_pipe #(
    .N_BOX     (8),
    .FIRST_BOX (0)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DES_SBOX_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  des_sbox_pipe #(
    .N_BOX     (1),
    .FIRST_BOX (0)
  ) u_one (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (1'b0),
    .in_valid  (in1_valid),
    .in_ready  (in1_ready),
    .in_data   (in1_data),
    .out_valid (out1_valid),
    .out_ready (1'b1),
    .out_data  (out1_data)
`ifdef DES_SBOX_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt1)
`endif
  );

  // Monitor: pop-and-compare on output handshake, then push on input accept.
  always @(negedge clk) begin
    if (!rst_n || clr) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_pop++;
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output actual=%h required=none", out_data);
        end else begin
          check("scoreboard", 48'(out_data), 48'(q.pop_front()));
        end
      end
      if (in_valid && in_ready) q.push_back(ref_sub(in_data));
    end
  end

  logic [47:0] burst [10] = '{48'h000000000000, 48'hFFFFFFFFFFFF, 48'h0123456789AB,
                              48'hFEDCBA987654, 48'hAAAAAAAAAAAA, 48'h555555555555,
                              48'h800000000001, 48'h7E7E7E7E7E7E, 48'h13579BDF2468,
                              48'hC0FFEE123456};

  initial begin
    int p;
    // Reset state
    repeat (2) step();
    at_neg();
    check("rst_out_valid", 48'(out_valid), 48'd0);
    check("rst_out_data", 48'(out_data), 48'd0);
    check("rst_in_ready", 48'(in_ready), 48'd1);
`ifdef DES_SBOX_CNT_EN
    check("rst_xfer_cnt", 48'(xfer_cnt), 48'd0);
`endif
    step();
    rst_n = 1'b1;

    // All-zero and all-one words
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 48'h0;
    step();
    in_valid = 1'b0;
    at_neg();
    check("zero_valid", 48'(out_valid), 48'd1);
    check("zero_data", 48'(out_data), 48'hEFA72C4D);
    step();
    in_valid = 1'b1;
    in_data  = 48'hFFFF_FFFF_FFFF;
    step();
    in_valid = 1'b0;
    at_neg();
    check("ones_data", 48'(out_data), 48'hD9CE3DCB);

    // Single-box instance
    in1_valid = 1'b1;
    in1_data  = 6'h3F;
    step();
    at_neg();
    check("one_valid_a", 48'(out1_valid), 48'd1);
    check("one_3f", 48'(out1_data), 48'hD);
    in1_data = 6'h00;
    step();
    in1_valid = 1'b0;
    at_neg();
    check("one_valid_b", 48'(out1_valid), 48'd1);
    check("one_00", 48'(out1_data), 48'hE);

    // Backpressure hold for 3 cycles
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 48'h0123456789AB;
    step();
    in_data = 48'hFEDCBA987654;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check("hold_valid", 48'(out_valid), 48'd1);
      check("hold_data", 48'(out_data), 48'(ref_sub(48'h0123456789AB)));
      check("hold_in_ready", 48'(in_ready), 48'd0);
      step();
    end
    p = n_pop;
    out_ready = 1'b1;
    at_neg();
    check("release_one_pop", 48'(n_pop - p), 48'd1);
    step();
    in_valid = 1'b0;
    at_neg();
    check("release_second_pop", 48'(n_pop - p), 48'd2);
    step();
    at_neg();
    check("release_drained", 48'(out_valid), 48'd0);

    // clr with simultaneous accept
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 48'h111111111111;
    step();
    clr       = 1'b1;
    in_data   = 48'h222222222222;
    out_ready = 1'b1;
    p = n_pop;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    at_neg();
    check("clr_valid", 48'(out_valid), 48'd0);
    step();
    at_neg();
    check("clr_no_emit", 48'(n_pop - p), 48'd0);

    // Reset during hold
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 48'h333333333333;
    step();
    in_valid = 1'b0;
    at_neg();
    check("prerst_valid", 48'(out_valid), 48'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 48'(out_valid), 48'd0);
    check("midrst_data", 48'(out_data), 48'd0);
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    at_neg();
    check("postrst_valid", 48'(out_valid), 48'd0);

    // Back-to-back burst of 10 words
    step();
    p = n_pop;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = burst[k];
      step();
    end
    in_valid = 1'b0;
    at_neg();
    check("burst_gapless", 48'(n_pop - p), 48'd10);

    // Random traffic and backpressure
    for (int k = 0; k < 80; k++) begin
      step();
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {16'($urandom), 32'($urandom)};
      out_ready = 1'($urandom_range(0, 1));
    end
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    at_neg();
    check("drain_queue_empty", 48'(q.size()), 48'd0);
    check("drain_valid", 48'(out_valid), 48'd0);

`ifdef DES_SBOX_CNT_EN
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    at_neg();
    check("cnt_clr0", 48'(xfer_cnt), 48'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = burst[k];
      step();
    end
    in_valid = 1'b0;
    step();
    at_neg();
    check("cnt_five", 48'(xfer_cnt), 48'd5);
    force u_dut.r_xfer_cnt = 16'hFFFD;
    #1;
    release u_dut.r_xfer_cnt;
    step();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = burst[k];
      step();
    end
    in_valid = 1'b0;
    step();
    at_neg();
    check("cnt_saturate", 48'(xfer_cnt), 48'hFFFF);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    at_neg();
    check("cnt_clr", 48'(xfer_cnt), 48'd0);
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
